// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: read-domain consumer for the async FIFO.
// Pops the FIFO's combinational-read head into a 2-entry skid buffer
// and presents it as a registered valid/ready stream.
//
// Ports:
//   clk, reset          read clock, async active-high reset
//   fifo_rempty/rdata   FIFO empty flag and head word
//   fifo_ren            pop strobe (no path from m_ready)
//   flush               sync discard of buffered words
//   m_valid/ready/data  output stream
//   xfer_count          accepted words (saturating)
//   stall_count         m_valid & ~m_ready cycles (saturating)
//
// Macro FIFO_RD_ADAPT_STATS_EN enables the statistics counters;
// when undefined both counters are tied to zero.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_rempty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  state;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] skid;
  logic                  valid_q;
  logic                  push;
  logic                  pop;

  // The skid slot absorbs the word popped in the cycle that
  // m_ready drops, so the pop never has to look at m_ready.
  assign fifo_ren = ~reset & ~fifo_rempty & ~flush
                  & (state != TWO);
  assign push     = fifo_ren;
  assign pop      = valid_q & m_ready;
  assign m_valid  = valid_q;
  assign m_data   = out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      out_reg <= '0;
      skid    <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      out_reg <= '0;
      skid    <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state   <= ONE;
            valid_q <= 1'b1;
            out_reg <= fifo_rdata;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_reg <= fifo_rdata;
          end else if (push) begin
            state <= TWO;
            skid  <= fifo_rdata;
          end else if (pop) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            state   <= ONE;
            out_reg <= skid;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_ADAPT_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] xfer_q;
  logic [CNT_WIDTH-1:0] stall_q;

  // Flush leaves the counters alone; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop && (xfer_q != CNT_MAX))
        xfer_q <= xfer_q + CNT_ONE;
      if (valid_q && !m_ready && (stall_q != CNT_MAX))
        stall_q <= stall_q + CNT_ONE;
    end
  end

  assign xfer_count  = xfer_q;
  assign stall_count = stall_q;
`else
  assign xfer_count  = '0;
  assign stall_count = '0;
`endif

endmodule
